// File: rtl/cpu_pkg.sv
// cpu_pkg: word width, LD/ST opcodes and data-memory FSM states shared with the CPU.
package cpu_pkg;
    localparam int DATA_W = 19;
    localparam logic [4:0] OP_LD = 5'b01100;
    localparam logic [4:0] OP_ST = 5'b01101;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} mem_state_t;
endpackage

// File: rtl/cpu_data_mem_ctrl_if.sv
// cpu_data_mem_ctrl_if: CPU load/store port as seen by the data-memory controller.
interface cpu_data_mem_ctrl_if;
    import cpu_pkg::*;
    logic mem_read;
    logic mem_write;
    logic [18:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic ready;
    logic busy;
    logic err;
    modport master(output mem_read, mem_write, address, wdata, input rdata, ready, busy, err);
    modport slave(input mem_read, mem_write, address, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/cpu_data_mem_ctrl_data_ram.sv
// data_ram: single-port synchronous RAM with registered read data; contents are never reset.
module data_ram
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= din;
        dout <= mem[idx];
    end
endmodule

// File: rtl/cpu_data_mem_ctrl.sv
// cpu_data_mem_ctrl: one-at-a-time LD/ST controller with configurable wait states,
// flagging conflicting and out-of-range requests instead of executing them.
module cpu_data_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic rst,
    cpu_data_mem_ctrl_if.slave bus
);
    mem_state_t state, next_state;
    logic [3:0] cnt;
    logic [4:0] op;
    logic conflict, bad_addr, fault, req, we, rd_done;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wd, dout, rdata_q, rd_val;
    logic ready, busy, err;
    assign req = bus.mem_read | bus.mem_write;
    assign fault = conflict | bad_addr;
    assign we = state == ACCESS && op == OP_ST && !fault;
    // conflicts capture as ST, so only genuine loads ever touch rdata
    assign rd_done = state == DONE && op == OP_LD;
    assign rd_val = bad_addr ? '0 : dout;
    assign bus.rdata = rd_done ? rd_val : rdata_q;
    assign bus.ready = ready;
    assign bus.busy = busy;
    assign bus.err = err;
    data_ram #(.ADDR_W(ADDR_W)) u_ram (.clk(clk), .we(we), .idx(idx), .din(wd), .dout(dout));
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE;
            WAIT:    next_state = cnt == 4'd0 ? ACCESS : WAIT;
            ACCESS:  next_state = DONE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            op <= OP_LD;
            conflict <= 1'b0;
            bad_addr <= 1'b0;
            idx <= '0;
            wd <= '0;
            rdata_q <= '0;
            ready <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                op <= bus.mem_write ? OP_ST : OP_LD;
                conflict <= bus.mem_read & bus.mem_write;
                bad_addr <= |bus.address[18:ADDR_W];
                idx <= bus.address[ADDR_W-1:0];
                wd <= bus.wdata;
                cnt <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_done) rdata_q <= rd_val;
            busy <= next_state != IDLE;
            ready <= next_state == DONE;
            err <= next_state == DONE && fault;
        end
    end
endmodule

// File: tb/tb_cpu_data_mem_ctrl.sv
// tb_cpu_data_mem_ctrl: directed and randomized checks of the data-memory controller
// against an array-based memory model; a second instance covers zero wait states.
module tb_cpu_data_mem_ctrl;
    import cpu_pkg::*;
    localparam int WS = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    cpu_data_mem_ctrl_if b0();
    cpu_data_mem_ctrl_if b1();
    cpu_data_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(WS)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    cpu_data_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    always #5 clk = ~clk;

    logic [18:0] model [256];
    logic [18:0] rmodel = '0;
    int lat, nbusy;
    logic e, post_rdy, post_busy;
    logic [18:0] rv;

    // Expected result of one request on the WS instance: returns err, updates memory and rdata.
    task automatic model_op(input bit rd, input bit wr, input logic [18:0] a, input logic [18:0] d, output logic xe);
        xe = (rd && wr) || a >= 19'd256;
        if (!xe && wr) model[a[7:0]] = d;
        if (rd && !wr) rmodel = a >= 19'd256 ? 19'd0 : model[a[7:0]];
    endtask

    // Issue one request at a negedge with the DUT idle; ends one cycle after ready.
    task automatic op(input bit sel, input bit rd, input bit wr, input logic [18:0] a, input logic [18:0] d);
        if (sel) begin
            b1.mem_read = rd; b1.mem_write = wr; b1.address = a; b1.wdata = d;
        end else begin
            b0.mem_read = rd; b0.mem_write = wr; b0.address = a; b0.wdata = d;
        end
        @(posedge clk);
        @(negedge clk);
        b0.mem_read = 0; b0.mem_write = 0; b1.mem_read = 0; b1.mem_write = 0;
        lat = 1;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (sel ? b1.busy : b0.busy) nbusy++;
            if (sel ? b1.ready : b0.ready) break;
            @(negedge clk);
            lat++;
        end
        e = sel ? b1.err : b0.err;
        rv = sel ? b1.rdata : b0.rdata;
        @(negedge clk);
        post_rdy = sel ? b1.ready : b0.ready;
        post_busy = sel ? b1.busy : b0.busy;
    endtask

    task automatic test_reset();
        b0.mem_read = 0; b0.mem_write = 0; b0.address = 0; b0.wdata = 0;
        b1.mem_read = 0; b1.mem_write = 0; b1.address = 0; b1.wdata = 0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({b0.ready, b0.busy, b0.err, b0.rdata} !== 22'd0) begin
            failures++;
            $display("FAIL reset0 got rdy=%b busy=%b err=%b rdata=%h want all 0", b0.ready, b0.busy, b0.err, b0.rdata);
        end
        checks++;
        if ({b1.ready, b1.busy, b1.err, b1.rdata} !== 22'd0) begin
            failures++;
            $display("FAIL reset1 got rdy=%b busy=%b err=%b rdata=%h want all 0", b1.ready, b1.busy, b1.err, b1.rdata);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic prefill();
        logic xe;
        for (int i = 0; i < 32; i++) begin
            logic [18:0] d = 19'($urandom) & 19'h3FFFF;
            op(0, 0, 1, 19'(i), d);
            model_op(0, 1, 19'(i), d, xe);
        end
    endtask

    task automatic test_write_latency();
        logic xe;
        op(0, 0, 1, 19'h03, 19'h5A5A5);
        model_op(0, 1, 19'h03, 19'h5A5A5, xe);
        checks++;
        if (lat !== WS + 2) begin failures++; $display("FAIL wr_latency got %0d want %0d", lat, WS + 2); end
        checks++;
        if (nbusy !== WS + 2) begin failures++; $display("FAIL wr_busy_cycles got %0d want %0d", nbusy, WS + 2); end
        checks++;
        if (e !== 1'b0) begin failures++; $display("FAIL wr_err got %b want 0", e); end
        checks++;
        if ({post_rdy, post_busy} !== 2'b00) begin failures++; $display("FAIL wr_after got rdy=%b busy=%b want 0 0", post_rdy, post_busy); end
    endtask

    task automatic test_readback();
        logic xe;
        op(0, 1, 0, 19'h03, 19'h0);
        model_op(1, 0, 19'h03, 19'h0, xe);
        checks++;
        if (rv !== 19'h5A5A5) begin failures++; $display("FAIL rd_data got %h want 5a5a5", rv); end
        checks++;
        if (lat !== WS + 2 || e !== 1'b0) begin failures++; $display("FAIL rd_status got lat=%0d err=%b want %0d 0", lat, e, WS + 2); end
        op(0, 0, 1, 19'h04, 19'h00001);
        model_op(0, 1, 19'h04, 19'h00001, xe);
        checks++;
        if (rv !== 19'h5A5A5) begin failures++; $display("FAIL rd_hold got %h want 5a5a5", rv); end
    endtask

    task automatic test_range();
        logic xe;
        op(0, 1, 0, 19'h00100, 19'h0);
        model_op(1, 0, 19'h00100, 19'h0, xe);
        checks++;
        if (e !== 1'b1 || lat !== WS + 2) begin failures++; $display("FAIL range_rd got err=%b lat=%0d want 1 %0d", e, lat, WS + 2); end
        checks++;
        if (rv !== 19'd0) begin failures++; $display("FAIL range_rdata got %h want 0", rv); end
        op(0, 0, 1, 19'h40000, 19'h7ABCD);
        model_op(0, 1, 19'h40000, 19'h7ABCD, xe);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL range_wr_err got %b want 1", e); end
        op(0, 1, 0, 19'h00000, 19'h0);
        model_op(1, 0, 19'h00000, 19'h0, xe);
        checks++;
        if (rv !== model[0]) begin failures++; $display("FAIL range_addr0 got %h want %h", rv, model[0]); end
    endtask

    task automatic test_conflict();
        logic xe;
        op(0, 1, 0, 19'h03, 19'h0);
        model_op(1, 0, 19'h03, 19'h0, xe);
        op(0, 1, 1, 19'h05, 19'h7FFFF);
        model_op(1, 1, 19'h05, 19'h7FFFF, xe);
        checks++;
        if (e !== 1'b1 || lat !== WS + 2) begin failures++; $display("FAIL conflict_err got err=%b lat=%0d want 1 %0d", e, lat, WS + 2); end
        checks++;
        if (rv !== rmodel) begin failures++; $display("FAIL conflict_rdata got %h want %h", rv, rmodel); end
        op(0, 1, 0, 19'h05, 19'h0);
        model_op(1, 0, 19'h05, 19'h0, xe);
        checks++;
        if (rv !== model[5]) begin failures++; $display("FAIL conflict_nowrite got %h want %h", rv, model[5]); end
    endtask

    task automatic test_reset_mid();
        logic xe;
        b0.mem_write = 1; b0.address = 19'h06; b0.wdata = 19'h12345;
        @(posedge clk);
        @(negedge clk);
        b0.mem_write = 0;
        checks++;
        if (b0.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy got %b want 1", b0.busy); end
        rst = 1;
        #1;
        checks++;
        if ({b0.ready, b0.busy, b0.err, b0.rdata} !== 22'd0) begin
            failures++;
            $display("FAIL rstmid_out got rdy=%b busy=%b err=%b rdata=%h want all 0", b0.ready, b0.busy, b0.err, b0.rdata);
        end
        rmodel = '0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        op(0, 1, 0, 19'h06, 19'h0);
        model_op(1, 0, 19'h06, 19'h0, xe);
        checks++;
        if (rv !== model[6]) begin failures++; $display("FAIL rstmid_nowrite got %h want %h", rv, model[6]); end
    endtask

    task automatic test_random();
        logic xe;
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 3));
            bit rd = kind == 0 || kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1);
            bit wr = kind == 1 || kind == 2 || (kind == 3 && !rd);
            logic [18:0] a = kind == 3 ? 19'(256 + $urandom_range(0, 524031)) : 19'($urandom_range(0, 31));
            logic [18:0] d = 19'($urandom);
            op(0, rd, wr, a, d);
            model_op(rd, wr, a, d, xe);
            checks++;
            if (lat !== WS + 2 || e !== xe || post_rdy !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_status got lat=%0d err=%b rdy_after=%b want %0d %b 0", i, lat, e, post_rdy, WS + 2, xe);
            end
            checks++;
            if (rv !== rmodel) begin failures++; $display("FAIL rand%0d_rdata got %h want %h", i, rv, rmodel); end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] val = 19'($urandom);
        logic [18:0] r1 = '0, r2 = '0;
        int t = 0, n = 0, t1 = -1, t2 = -1;
        op(1, 0, 1, 19'h02, val);
        b1.mem_read = 1; b1.address = 19'h02;
        @(posedge clk);
        while (n < 2 && t < 30) begin
            @(negedge clk);
            t++;
            if (b1.ready) begin
                n++;
                if (n == 1) begin t1 = t; r1 = b1.rdata; end
                else begin t2 = t; r2 = b1.rdata; end
            end
        end
        b1.mem_read = 0;
        checks++;
        if (t1 !== 2) begin failures++; $display("FAIL b2b_first got %0d want 2", t1); end
        checks++;
        if (t2 - t1 !== 3) begin failures++; $display("FAIL b2b_spacing got %0d want 3", t2 - t1); end
        checks++;
        if (r1 !== val || r2 !== val) begin failures++; $display("FAIL b2b_rdata got %h %h want %h", r1, r2, val); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (b1.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b want 0", b1.busy); end
    endtask

    initial begin
        test_reset();
        prefill();
        test_write_latency();
        test_readback();
        test_range();
        test_conflict();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
